complex_int_round_out: RTL



---
 rtl/axis_pkg.sv | 48 ++++
 rtl/cplx_fifo.sv | 57 +++++
 rtl/complex_int_round_out.sv | 85 ++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Sample types shared by the window-function datapath, plus the rounding/saturation
// helper that narrows multiplier products back to integer samples.
package axis_pkg;

    typedef struct packed {
        logic signed [31:0] im;
        logic signed [31:0] re;
    } sample_t;

    typedef struct packed {
        logic signed [15:0] im;
        logic signed [15:0] re;
    } sample_t_int;

    // Round half-up by adding 2^(shift-1), shift arithmetically, clamp to 16 bits.
    function automatic logic signed [15:0] round_comp(input logic signed [31:0] x,
                                                      input int shift,
                                                      output logic ovf);
        logic signed [32:0] half;
        logic signed [32:0] t;
        logic signed [32:0] s;
        half = (33'sd1 <<< shift) >>> 1;
        t    = {x[31], x} + half;
        s    = t >>> shift;
        if (s > 33'sd32767) begin
            ovf        = 1'b1;
            round_comp = 16'sh7fff;
        end else if (s < -33'sd32768) begin
            ovf        = 1'b1;
            round_comp = 16'sh8000;
        end else begin
            ovf        = 1'b0;
            round_comp = s[15:0];
        end
    endfunction

    function automatic sample_t_int round_sat(input sample_t z, input int shift,
                                              output logic ovf);
        logic ovf_re;
        logic ovf_im;
        sample_t_int r;
        r.re      = round_comp(z.re, shift, ovf_re);
        r.im      = round_comp(z.im, shift, ovf_im);
        ovf       = ovf_re | ovf_im;
        round_sat = r;
    endfunction

endpackage

// File: rtl/cplx_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; head reads as zero
// while empty so downstream data is clean before the first sample.
module cplx_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/complex_int_round_out.sv
// Draining stage of the enable-gated complex multiplier: credit-based enable, valid/last
// tag pipeline, round/saturate to 16 bits and an AXI-Stream master behind a FWFT FIFO.
module complex_int_round_out
    import axis_pkg::*;
#(
    parameter int unsigned PIPE_NUM   = 10,
    parameter int unsigned SHIFT      = 15,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        mult_en,
    input  sample_t     z,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [15:0] ovf_cnt
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [PIPE_NUM-1:0] tag_valid_q, tag_last_q;
    logic [CntW-1:0]     fifo_count;
    logic                fifo_empty;
    logic [32:0]         fifo_rdata;
    logic [15:0]         ovf_cnt_q;
    sample_t_int         z_rnd;
    logic                z_ovf;
    logic                push, pop;

    // Enable depends only on registered occupancy, so m_tready never reaches it.
    assign mult_en = (fifo_count < CntW'(FIFO_DEPTH));
    assign s_ready = mult_en;

    // Tags freeze with the multiplier; only enabled edges carry a result out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_q <= '0;
            tag_last_q  <= '0;
        end else if (mult_en) begin
            tag_valid_q <= {tag_valid_q[PIPE_NUM-2:0], s_valid};
            tag_last_q  <= {tag_last_q[PIPE_NUM-2:0], s_last};
        end
    end

    always_comb begin
        z_ovf = 1'b0;
        z_rnd = round_sat(z, int'(SHIFT), z_ovf);
    end

    assign push = mult_en & tag_valid_q[PIPE_NUM-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (push && z_ovf && (ovf_cnt_q != 16'hffff)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'd1;
        end
    end

    cplx_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({tag_last_q[PIPE_NUM-1], z_rnd}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_tvalid = ~fifo_empty;
    assign pop      = m_tvalid & m_tready;
    assign m_tdata  = fifo_rdata[31:0];
    assign m_tlast  = fifo_rdata[32];
    assign ovf_cnt  = ovf_cnt_q;

endmodule
